// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the IF/LSU memory-port arbiter.
// Defines the arbiter states, the transaction owner tag and the latched memory command.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_BE_W-1:0]   be;
  } mem_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_cmd_t fetch_cmd(input logic [ARB_ADDR_W-1:0] addr);
    mem_cmd_t c;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = '0;
    c.be    = '1;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified memory port between instruction fetch (IF)
// and load/store (LSU), one transaction outstanding at a time. LSU has fixed priority.
// Optional build macro MEM_ARB_STARVE_EN adds a starvation guard that forces an IF
// grant after STARVE_LIMIT consecutive arbitrations lost to the LSU.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stall_o,

  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  output logic                lsu_ack_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_stall_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  // The command struct is sized by the package, so the parameters must agree with it.
  if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W || STARVE_LIMIT < 1) begin : g_param_check
    $error("mem_arbiter: ADDR_W/DATA_W must match mem_arb_pkg widths and STARVE_LIMIT must be >= 1");
  end

  logic [1:0] rst_sync;
  logic       rst_n;
  arb_state_e state;
  owner_e     owner;
  mem_cmd_t   cmd_q;
  logic       any_req;
  logic       grant_if;

  // Reset asserts immediately and releases two clock edges later, in step with the clock.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n   = rst_sync[1];
  assign any_req = if_req_i | lsu_req_i;

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_if   = if_req_i & (~lsu_req_i | starve_hit);

  // Count IDLE arbitrations IF loses to the LSU; any IF grant starts the count over.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (grant_if)                    starve_cnt <= '0;
      else if (if_req_i && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign grant_if = if_req_i & ~lsu_req_i;
`endif

  // Transaction sequencer: arbitrate, issue, wait for the response, acknowledge the owner.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      cmd_q       <= '0;
      mem_req_o   <= 1'b0;
      if_ack_o    <= 1'b0;
      lsu_ack_o   <= 1'b0;
      if_rdata_o  <= '0;
      lsu_rdata_o <= '0;
    end else begin
      mem_req_o <= 1'b0;
      if_ack_o  <= 1'b0;
      lsu_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            if (grant_if) begin
              owner <= OWN_IF;
              cmd_q <= fetch_cmd(if_addr_i);
            end else begin
              owner <= OWN_LSU;
              cmd_q <= '{we: lsu_we_i, addr: lsu_addr_i, wdata: lsu_wdata_i, be: lsu_be_i};
            end
            mem_req_o <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (owner == OWN_IF) begin
              if_rdata_o <= mem_rdata_i;
              if_ack_o   <= 1'b1;
            end else begin
              lsu_rdata_o <= mem_rdata_i;
              lsu_ack_o   <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign mem_be_o    = cmd_q.be;

  assign if_stall_o  = if_req_i & ~if_ack_o;
  assign lsu_stall_o = lsu_req_i & ~lsu_ack_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Build with +define+MEM_ARB_STARVE_EN to exercise the starvation guard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        CPU_RESETN;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        if_stall_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_be_i;
  logic        lsu_ack_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        rv_model, rv_spur;
  logic [31:0] rd_model;

  assign mem_rvalid_i = rv_model | rv_spur;
  assign mem_rdata_i  = rv_spur ? 32'hBAD0_BAD0 : rd_model;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (CPU_RESETN),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .if_stall_o  (if_stall_o),
    .lsu_req_i   (lsu_req_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_be_i    (lsu_be_i),
    .lsu_ack_o   (lsu_ack_o),
    .lsu_rdata_o (lsu_rdata_o),
    .lsu_stall_o (lsu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;   // absolute issue cycle, -1 = don't care
    int          gap;   // cycles after the previous ack, -1 = don't care
  } issue_t;

  typedef struct {
    bit          lsu;
    logic [31:0] rdata;
    int          lat;   // cycles from mem_req_o to ack
  } ack_t;

  issue_t exp_issue_q[$];
  ack_t   exp_ack_q[$];
  issue_t cur_exp;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_issue = 0;
  int n_ack = 0;
  int issue_cyc = 0;
  int last_ack_cyc = -100;
  int resp_k = 1;
  bit chk_stable = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic push_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int c, input int g);
    issue_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.cyc = c; e.gap = g;
    exp_issue_q.push_back(e);
  endtask

  task automatic push_ack(input bit lsu, input logic [31:0] rdata, input int lat);
    ack_t e;
    e.lsu = lsu; e.rdata = rdata; e.lat = lat;
    exp_ack_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT issues or acknowledges.
  always @(negedge clk) begin
    if (mem_req_o) begin
      n_issue++;
      issue_cyc = cyc;
      if (exp_issue_q.size() == 0) begin
        check("issue_unexpected", 1, 0);
      end else begin
        issue_t e;
        e = exp_issue_q.pop_front();
        cur_exp = e;
        check("issue_cmd", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
              {e.we, e.addr, e.wdata, e.be});
        if (e.cyc >= 0) check("issue_cycle", cyc, e.cyc);
        if (e.gap >= 0) check("issue_after_ack", cyc - last_ack_cyc, e.gap);
      end
    end
    if (if_ack_o || lsu_ack_o) begin
      n_ack++;
      last_ack_cyc = cyc;
      if (exp_ack_q.size() == 0) begin
        check("ack_unexpected", {if_ack_o, lsu_ack_o}, 0);
      end else begin
        ack_t a;
        a = exp_ack_q.pop_front();
        check("ack_port", {if_ack_o, lsu_ack_o}, a.lsu ? 2'b01 : 2'b10);
        check("ack_rdata", a.lsu ? lsu_rdata_o : if_rdata_o, a.rdata);
        check("ack_latency", cyc - issue_cyc, a.lat);
      end
    end
  end

  // Memory model: answers each issue resp_k cycles later and watches command stability.
  initial begin
    logic [31:0] a;
    rv_model = 1'b0;
    rd_model = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_o) begin
        a = mem_addr_o;
        for (int i = 0; i < resp_k; i++) begin
          @(posedge clk); #1;
          if (chk_stable)
            check("cmd_stable", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                  {cur_exp.we, cur_exp.addr, cur_exp.wdata, cur_exp.be});
        end
        rv_model = 1'b1;
        rd_model = mem_val(a);
        @(posedge clk); #1;
        rv_model = 1'b0;
        rd_model = '0;
      end
    end
  end

  // Drives requests until n acks arrive; IF drops on its ack, LSU after lsu_drop acks.
  task automatic run_acks(input int n, input int lsu_drop);
    int got = 0;
    int lsu_got = 0;
    int budget = 0;
    while (got < n && budget < 300) begin
      @(posedge clk); #1;
      budget++;
      if (if_ack_o) begin
        got++;
        if_req_i = 1'b0;
      end
      if (lsu_ack_o) begin
        got++;
        lsu_got++;
        if (lsu_got >= lsu_drop) lsu_req_i = 1'b0;
      end
    end
    check("ack_count_in_budget", got, n);
    if_req_i  = 1'b0;
    lsu_req_i = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] ird, input logic [31:0] lrd,
                               input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be);
    check({tag, "_acks_req"}, {if_ack_o, lsu_ack_o, mem_req_o}, 3'b000);
    check({tag, "_if_rdata"}, if_rdata_o, ird);
    check({tag, "_lsu_rdata"}, lsu_rdata_o, lrd);
    check({tag, "_mem_cmd"}, {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, {we, addr, wd, be});
  endtask

  initial begin
    int m, na, ni;
    CPU_RESETN = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_be_i = '0;
    rv_spur = 1'b0;

    // Reset values
    repeat (4) @(negedge clk);
    check_outputs("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    CPU_RESETN = 1'b1;
    repeat (4) @(posedge clk);

    // Single IF read, k=1
    resp_k = 1;
    @(posedge clk); #1;
    m = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    push_issue(1'b0, 32'h0000_0100, 32'h0, 4'hF, m + 1, -1);
    push_ack(1'b0, 32'hDEAD_BEEF, 2);
    @(negedge clk); check("if_stall_n0", if_stall_o, 1'b1);
    @(negedge clk); check("if_stall_n1", if_stall_o, 1'b1);
    @(negedge clk); check("if_stall_n2", if_stall_o, 1'b1);
    @(negedge clk); check("if_stall_ack", {if_stall_o, if_ack_o}, 2'b01);
    @(posedge clk); #1;
    if_req_i = 1'b0;
    repeat (2) @(posedge clk);

    // Spurious rvalid in IDLE with no requests
    na = n_ack; ni = n_issue;
    @(posedge clk); #1; rv_spur = 1'b1;
    @(posedge clk); #1; rv_spur = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("spur_idle", 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    check("spur_no_ack", n_ack - na, 0);
    check("spur_no_issue", n_issue - ni, 0);

    // Simultaneous IF and LSU write: LSU first, IF in the IDLE after the LSU ack
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h0000_0080;
    lsu_wdata_i = 32'h1234_5678; lsu_be_i = 4'hF;
    push_issue(1'b1, 32'h0000_0080, 32'h1234_5678, 4'hF, -1, -1);
    push_ack(1'b1, 32'h5A5A_5ADA, 2);
    push_issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, -1, 2);
    push_ack(1'b0, 32'h5A5A_5A1A, 2);
    run_acks(2, 1);
    repeat (2) @(posedge clk);

    // LSU byte write, k=3
    resp_k = 3;
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h0000_0084;
    lsu_wdata_i = 32'h0000_AB00; lsu_be_i = 4'h2;
    push_issue(1'b1, 32'h0000_0084, 32'h0000_AB00, 4'h2, -1, -1);
    push_ack(1'b1, 32'h5A5A_5ADE, 4);
    run_acks(1, 1);
    repeat (3) @(posedge clk);

    // LSU held continuously with IF pending
    resp_k = 1;
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0000_0200;
    lsu_wdata_i = 32'h0; lsu_be_i = 4'hF;
`ifdef MEM_ARB_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      push_issue(1'b0, 32'h0000_0200, 32'h0, 4'hF, -1, -1);
      push_ack(1'b1, 32'h5A5A_585A, 2);
    end
    push_issue(1'b0, 32'h0000_0300, 32'h0, 4'hF, -1, -1);
    push_ack(1'b0, 32'h5A5A_595A, 2);
    push_issue(1'b0, 32'h0000_0200, 32'h0, 4'hF, -1, -1);
    push_ack(1'b1, 32'h5A5A_585A, 2);
`else
    for (int i = 0; i < 5; i++) begin
      push_issue(1'b0, 32'h0000_0200, 32'h0, 4'hF, -1, -1);
      push_ack(1'b1, 32'h5A5A_585A, 2);
    end
    push_issue(1'b0, 32'h0000_0300, 32'h0, 4'hF, -1, 2);
    push_ack(1'b0, 32'h5A5A_595A, 2);
`endif
    run_acks(6, 5);
    repeat (3) @(posedge clk);

    // Reset asserted in WAIT, late rvalid after release
    resp_k = 10;
    chk_stable = 1'b0;
    na = n_ack; ni = n_issue;
    @(posedge clk); #1;
    m = cyc;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0000_0088; lsu_be_i = 4'hF;
    push_issue(1'b0, 32'h0000_0088, 32'h0, 4'hF, m + 1, -1);
    repeat (3) @(posedge clk); #1;
    CPU_RESETN = 1'b0;
    lsu_req_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    CPU_RESETN = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_outputs("rst_wait", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("rst_wait_no_ack", n_ack - na, 0);
    check("rst_wait_issue_count", n_issue - ni, 1);
    check("rst_wait_state_idle", dut.state, IDLE);

    check("issue_queue_drained", exp_issue_q.size(), 0);
    check("ack_queue_drained", exp_ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
